// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit:
// state enum, ALU/opcode encodings and datapath mux select values.
package mc_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } statetype_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Data-processing cmd field values (Funct[4:1]).
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Bundle between instruction-register fields, the control unit and the
// condition logic / datapath muxes. state_dbg exposes the FSM state.
interface mc_ctrl_fsm_if #(parameter int STATE_W = 4);
  logic [1:0]         Op;
  logic [5:0]         Funct;
  logic [3:0]         Rd;
  logic               IRWrite;
  logic               AdrSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic               NextPC;
  logic               RegW;
  logic               MemW;
  logic               PCS;
  logic [1:0]         FlagW;
  logic [1:0]         ALUControl;
  logic [1:0]         ImmSrc;
  logic [1:0]         RegSrc;
  logic [STATE_W-1:0] state_dbg;

  // No handshake: the control unit consumes the instruction fields every
  // cycle and its outputs are valid combinationally in the same cycle.
  modport master (
    input  Op, Funct, Rd,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
           RegW, MemW, PCS, FlagW, ALUControl, ImmSrc, RegSrc, state_dbg
  );

  modport slave (
    output Op, Funct, Rd,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
           RegW, MemW, PCS, FlagW, ALUControl, ImmSrc, RegSrc, state_dbg
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// ALU command decode: maps ALUOp and Funct to ALUControl and the
// pre-condition flag-write enables.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic       alu_op,
  input  logic [5:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w
);

  logic cmd_valid;

  always_comb begin
    alu_control = ALU_ADD;
    cmd_valid   = 1'b0;
    flag_w      = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        CMD_ADD: begin alu_control = ALU_ADD; cmd_valid = 1'b1; end
        CMD_SUB: begin alu_control = ALU_SUB; cmd_valid = 1'b1; end
        CMD_AND: begin alu_control = ALU_AND; cmd_valid = 1'b1; end
        CMD_ORR: begin alu_control = ALU_ORR; cmd_valid = 1'b1; end
        default: ;
      endcase
      // Carry/overflow only make sense for the arithmetic commands.
      flag_w[1] = funct[0] & cmd_valid;
      flag_w[0] = funct[0] & cmd_valid &
                  ((alu_control == ALU_ADD) || (alu_control == ALU_SUB));
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control unit: Moore main FSM plus ALU and PC-select decode,
// producing the pre-condition write enables for the condition logic.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master bus
);

  statetype_e state_q, state_d;

  logic       ir_write, adr_src, next_pc, reg_w, mem_w, branch, alu_op;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [1:0] alu_control, flag_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    alu_src_a  = SRCA_RN;
    alu_src_b  = SRCB_RM;
    result_src = RES_ALUOUT;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        case (bus.Op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_d   = bus.Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
      end
      MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECUTER: begin
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        alu_src_b = SRCB_IMM;
        alu_op    = 1'b1;
        state_d   = ALUWB;
      end
      ALUWB: reg_w = 1'b1;
      BRANCH: begin
        alu_src_a  = SRCA_ALUOUT;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        branch     = 1'b1;
      end
      // UNKNOWN and any illegal encoding skip the instruction.
      default: state_d = FETCH;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct       (bus.Funct),
    .alu_control (alu_control),
    .flag_w      (flag_w)
  );

  assign bus.IRWrite    = ir_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.NextPC     = next_pc;
  assign bus.RegW       = reg_w;
  assign bus.MemW       = mem_w;
  // A write to R15 is a PC write, so it must be gated by the condition too.
  assign bus.PCS        = (reg_w & (bus.Rd == 4'hF)) | branch;
  assign bus.FlagW      = flag_w;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
  assign bus.state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle vector table covering every
// instruction class, plus hand-written asynchronous reset sequences.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    statetype_e  st;
    logic [15:0] ctl;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs[$];

  mc_ctrl_fsm_if #(.STATE_W(4)) bus ();

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, PCS, FlagW, ALUControl}
  function automatic logic [15:0] mk(input logic ir, input logic adr, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] rs, input logic npc,
                                     input logic rw, input logic mw, input logic pcs,
                                     input logic [1:0] fw, input logic [1:0] ac);
    return {ir, adr, sa, sb, rs, npc, rw, mw, pcs, fw, ac};
  endfunction

  function automatic logic [15:0] actual_ctl();
    return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.NextPC,
            bus.RegW, bus.MemW, bus.PCS, bus.FlagW, bus.ALUControl};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                     input statetype_e st, input logic [15:0] ctl);
    vec_t v;
    v.op = op; v.funct = funct; v.rd = rd; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    bus.Op = op; bus.Funct = funct; bus.Rd = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] c_fetch, c_decode, c_zero;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(2'b00, 6'b000000, 4'd0);

    c_fetch  = mk(1, 0, 2'b01, 2'b10, 2'b10, 1, 0, 0, 0, 2'b00, 2'b00);
    c_decode = mk(0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00);
    c_zero   = mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00);

    // ADDS R1, register operand
    add(2'b00, 6'b001001, 4'd1, FETCH,    c_fetch);
    add(2'b00, 6'b001001, 4'd1, DECODE,   c_decode);
    add(2'b00, 6'b001001, 4'd1, EXECUTER, mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00));
    add(2'b00, 6'b001001, 4'd1, ALUWB,    mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00));
    // ANDS immediate, Rd=15
    add(2'b00, 6'b100001, 4'd15, FETCH,    c_fetch);
    add(2'b00, 6'b100001, 4'd15, DECODE,   c_decode);
    add(2'b00, 6'b100001, 4'd15, EXECUTEI, mk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 2'b10, 2'b10));
    add(2'b00, 6'b100001, 4'd15, ALUWB,    mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 2'b00, 2'b00));
    // SUB without S
    add(2'b00, 6'b000100, 4'd2, FETCH,    c_fetch);
    add(2'b00, 6'b000100, 4'd2, DECODE,   c_decode);
    add(2'b00, 6'b000100, 4'd2, EXECUTER, mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01));
    add(2'b00, 6'b000100, 4'd2, ALUWB,    mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00));
    // SUBS: both flag groups
    add(2'b00, 6'b000101, 4'd7, FETCH,    c_fetch);
    add(2'b00, 6'b000101, 4'd7, DECODE,   c_decode);
    add(2'b00, 6'b000101, 4'd7, EXECUTER, mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 2'b01));
    add(2'b00, 6'b000101, 4'd7, ALUWB,    mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00));
    // ORRS immediate: NZ only
    add(2'b00, 6'b111001, 4'd5, FETCH,    c_fetch);
    add(2'b00, 6'b111001, 4'd5, DECODE,   c_decode);
    add(2'b00, 6'b111001, 4'd5, EXECUTEI, mk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 2'b10, 2'b11));
    add(2'b00, 6'b111001, 4'd5, ALUWB,    mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00));
    // unsupported cmd 1111 with S=1
    add(2'b00, 6'b011111, 4'd6, FETCH,    c_fetch);
    add(2'b00, 6'b011111, 4'd6, DECODE,   c_decode);
    add(2'b00, 6'b011111, 4'd6, EXECUTER, mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    add(2'b00, 6'b011111, 4'd6, ALUWB,    mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00));
    // LDR R3: 5 cycles
    add(2'b01, 6'b011001, 4'd3, FETCH,  c_fetch);
    add(2'b01, 6'b011001, 4'd3, DECODE, c_decode);
    add(2'b01, 6'b011001, 4'd3, MEMADR, mk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    add(2'b01, 6'b011001, 4'd3, MEMRD,  mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    add(2'b01, 6'b011001, 4'd3, MEMWB,  mk(0, 0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 0, 2'b00, 2'b00));
    // LDR PC
    add(2'b01, 6'b011001, 4'd15, FETCH,  c_fetch);
    add(2'b01, 6'b011001, 4'd15, DECODE, c_decode);
    add(2'b01, 6'b011001, 4'd15, MEMADR, mk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    add(2'b01, 6'b011001, 4'd15, MEMRD,  mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    add(2'b01, 6'b011001, 4'd15, MEMWB,  mk(0, 0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 1, 2'b00, 2'b00));
    // STR
    add(2'b01, 6'b011000, 4'd4, FETCH,  c_fetch);
    add(2'b01, 6'b011000, 4'd4, DECODE, c_decode);
    add(2'b01, 6'b011000, 4'd4, MEMADR, mk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    add(2'b01, 6'b011000, 4'd4, MEMWR,  mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00));
    // B
    add(2'b10, 6'b100000, 4'd0, FETCH,  c_fetch);
    add(2'b10, 6'b100000, 4'd0, DECODE, c_decode);
    add(2'b10, 6'b100000, 4'd0, BRANCH, mk(0, 0, 2'b10, 2'b01, 2'b10, 0, 0, 0, 1, 2'b00, 2'b00));
    // undefined Op=11
    add(2'b11, 6'b001001, 4'd15, FETCH,   c_fetch);
    add(2'b11, 6'b001001, 4'd15, DECODE,  c_decode);
    add(2'b11, 6'b001001, 4'd15, UNKNOWN, c_zero);
    add(2'b00, 6'b000000, 4'd0, FETCH,    c_fetch);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(bus.state_dbg), 32'(FETCH));
    check("reset_ctl", 32'(actual_ctl()), 32'(c_fetch));

    // release mid-cycle; FETCH holds until the next rising edge
    reset = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].funct, vecs[i].rd);
      #1;
      check($sformatf("vec%0d_state", i), 32'(bus.state_dbg), 32'(vecs[i].st));
      check($sformatf("vec%0d_ctl", i), 32'(actual_ctl()), 32'(vecs[i].ctl));
      check($sformatf("vec%0d_immsrc", i), 32'(bus.ImmSrc), 32'(vecs[i].op));
      check($sformatf("vec%0d_regsrc", i), 32'(bus.RegSrc),
            32'({vecs[i].op == 2'b01, vecs[i].op == 2'b10}));
      step();
    end

    // async reset in the middle of EXECUTER
    drive(2'b00, 6'b001001, 4'd15);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst1_state", 32'(bus.state_dbg), 32'(FETCH));
    step();
    step();
    check("rst1_in_exec", 32'(bus.state_dbg), 32'(EXECUTER));
    #1;
    reset = 1'b0;
    #1;
    check("rst1_async_state", 32'(bus.state_dbg), 32'(FETCH));
    check("rst1_irwrite", 32'(bus.IRWrite), 32'd1);
    check("rst1_nextpc", 32'(bus.NextPC), 32'd1);
    check("rst1_regw", 32'(bus.RegW), 32'd0);
    check("rst1_flagw", 32'(bus.FlagW), 32'd0);
    step();
    check("rst1_held", 32'(bus.state_dbg), 32'(FETCH));
    reset = 1'b1;
    #1;
    check("rst1_release_wait", 32'(bus.state_dbg), 32'(FETCH));
    step();
    check("rst1_release_edge", 32'(bus.state_dbg), 32'(DECODE));

    // async reset drops a pending MemW in MEMWR
    drive(2'b01, 6'b011000, 4'd4);
    step();
    check("rst2_memadr", 32'(bus.state_dbg), 32'(MEMADR));
    step();
    check("rst2_memw_on", 32'(bus.MemW), 32'd1);
    reset = 1'b0;
    #1;
    check("rst2_memw_drop", 32'(bus.MemW), 32'd0);
    check("rst2_state", 32'(bus.state_dbg), 32'(FETCH));
    reset = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control unit for the ARM-subset datapath. It is the producer side of the conditional-logic interface: it generates FlagW, PCS, RegW, MemW and NextPC, which the condition logic gates with CondEx.
- Contains a Moore main FSM plus combinational ALU and PC-select decode.
- Sits between the instruction register fields (Op, Funct, Rd) and the condition logic and datapath muxes.

Parameters:
- STATE_W, 4, width of the state register (11 states used).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. 0 forces state FETCH immediately.
- Op  in  2  instr[27:26]; 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  in  6  instr[25:20]. [5]=I, [4:1]=cmd, [0]=S (DP) or L (mem).
- Rd  in  4  instr[15:12].
- IRWrite  out  1  instruction register load enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALU result register.
- ALUSrcA  out  2  00=Rn, 01=PC, 10=ALUOut.
- ALUSrcB  out  2  00=Rm, 01=ExtImm, 10=const 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- NextPC  out  1  unconditional PC write (fetch).
- RegW  out  1  pre-condition register write.
- MemW  out  1  pre-condition memory write.
- PCS  out  1  pre-condition PC source/write.
- FlagW  out  2  pre-condition flag write: [1]=NZ, [0]=CV.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).

Behaviour:
- Reset (reset=0, async): state=FETCH. Outputs are those of FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, AdrSrc=0; all others 0. Reset deassertion is sampled at the next rising edge.
- State advances on every rising edge; there are no stalls.
- Outputs are combinational from state plus Op/Funct/Rd.
- Unlisted outputs are 0 in every state.
- State table (outputs; next state):
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1; next DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next: Op=01 -> MEMADR; Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
  - MEMADR: ALUSrcA=00, ALUSrcB=01. Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD: AdrSrc=1, ResultSrc=00; next MEMWB.
  - MEMWB: ResultSrc=01, RegW=1; next FETCH.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1; next FETCH.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1; next ALUWB.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1; next ALUWB.
  - ALUWB: ResultSrc=00, RegW=1; next FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1; next FETCH.
  - UNKNOWN: all controls 0 (instruction skipped); next FETCH.
  - Illegal state encodings: treat as UNKNOWN; next FETCH.
- ALU decode (ALUOp internal):
  - ALUOp=1: cmd 0100 -> 00, 0010 -> 01, 0000 -> 10, 1100 -> 11, any other cmd -> 00 with FlagW=00.
  - ALUOp=1: FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl==00 or 01), valid cmds only.
  - ALUOp=0: ALUControl=00, FlagW=00.
- PCS = (RegW & Rd==4'hF) | Branch. PCS is asserted only in ALUWB, MEMWB (Rd=15) or BRANCH.
- Latency per instruction class:
  - DP: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Undefined: 3 cycles.
- Reset mid-instruction: immediate return to FETCH. Any pending RegW/MemW is dropped in the same cycle (asynchronous).

Decomposition:
- Shared package mc_ctrl_pkg:
  - state enum statetype_e (FETCH..UNKNOWN).
  - ALUControl localparams (ALU_ADD/SUB/AND/ORR).
  - Op localparams (OP_DP/OP_MEM/OP_BR).
  - src-mux encodings.
- One sub-module, mc_alu_decoder: combinational map of ALUOp, Funct -> ALUControl, FlagW. The FSM, PC logic and instruction decode stay in mc_ctrl_fsm.

Test Plan:
- Reset: hold reset=0 mid-EXECUTER, then release. Required: state=FETCH at once, IRWrite=1, NextPC=1, RegW=0, FlagW=00.
- ADDS R1 (Op=00, Funct=001001, Rd=1): cycles FETCH, DECODE, EXECUTER, ALUWB, FETCH. In EXECUTER: ALUControl=00, FlagW=11, ALUSrcB=00. In ALUWB: RegW=1, PCS=0.
- ANDS immediate, Rd=15 (Funct=100001): path includes EXECUTEI with ALUSrcB=01, ALUControl=10, FlagW=10. ALUWB has RegW=1, PCS=1.
- LDR (Op=01, Funct=011001): MEMADR -> MEMRD (AdrSrc=1) -> MEMWB (ResultSrc=01, RegW=1); 5 cycles total.
- STR (Funct=011000): MEMWR has MemW=1, RegW=0. B (Op=10): BRANCH has ALUSrcA=10, PCS=1; 3 cycles.
- Op=11: UNKNOWN with all controls 0, then FETCH. Unsupported cmd 1111: ALUControl=00, FlagW=00.
